// File: rtl/class_switch_n.sv
// Class switch: steers each registered input word by its class field into one of NUM_CH FIFOs.
// Latency: 2 cycles from input sample to earliest data_out (input register, then FIFO write, then pop).
// Backpressure: pause is advisory (OR of almost_full); words to a full FIFO are dropped and flagged.
module class_switch_n #(
  parameter int DATA_W     = 10,
  parameter int CLASS_LSB  = 8,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_TH      = 6,
  parameter int AE_TH      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        read,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        valid_out,
  output logic [NUM_CH-1:0]        fifo_empty,
  output logic [NUM_CH-1:0]        fifo_full,
  output logic [NUM_CH-1:0]        almost_full,
  output logic [NUM_CH-1:0]        almost_empty,
  output logic [NUM_CH-1:0]        fifo_error,
  output logic                     pause
);

  localparam int CLASS_W = $clog2(NUM_CH);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  // Input register
  logic [DATA_W-1:0] in_dat_q, in_dat_d;
  logic              in_vld_q, in_vld_d;

  // Per-channel FIFO state
  logic [DATA_W-1:0] mem_q    [NUM_CH][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d    [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [DATA_W-1:0] dout_q   [NUM_CH];
  logic [DATA_W-1:0] dout_d   [NUM_CH];
  logic [NUM_CH-1:0] vout_q, vout_d;
  logic [NUM_CH-1:0] err_q, err_d;

  // Decoded per-channel controls
  logic [CLASS_W-1:0] cls;
  logic [NUM_CH-1:0]  is_empty, is_full, is_af, is_ae;
  logic [NUM_CH-1:0]  wr_req, rd_acc, wr_acc;

  assign cls = in_dat_q[CLASS_LSB +: CLASS_W];

  // Status flags are pure decodes of the registered counts
  always_comb begin
    is_empty = '0;
    is_full  = '0;
    is_af    = '0;
    is_ae    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      is_empty[i] = (cnt_q[i] == '0);
      is_full[i]  = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
      is_af[i]    = (cnt_q[i] >= CNT_W'(AF_TH));
      is_ae[i]    = (cnt_q[i] <= CNT_W'(AE_TH));
    end
  end

  // Next-state: routing, push/pop, count update and sticky error detection
  always_comb begin
    in_dat_d = data_in;
    in_vld_d = valid_in;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    vout_d   = '0;
    err_d    = err_q;
    wr_req   = '0;
    rd_acc   = '0;
    wr_acc   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // The enable mask is applied to the registered word, so a disabled class never touches its FIFO.
      wr_req[i] = in_vld_q && (cls == CLASS_W'(i)) && ch_en[i];
      rd_acc[i] = read[i] && !is_empty[i];
      // A full FIFO still takes the write when a pop frees the head slot on the same edge.
      wr_acc[i] = wr_req[i] && (!is_full[i] || rd_acc[i]);
      vout_d[i] = rd_acc[i];

      if (rd_acc[i]) begin
        dout_d[i]   = mem_q[i][rd_ptr_q[i]];
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      end
      if (wr_acc[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_dat_q;
        wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
      end

      case ({wr_acc[i], rd_acc[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase

      // Overflow (dropped write) or underflow (pop of an empty FIFO, no same-cycle bypass).
      if ((wr_req[i] && !wr_acc[i]) || (read[i] && is_empty[i])) begin
        err_d[i] = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset; queued words are discarded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_dat_q <= '0;
      in_vld_q <= 1'b0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '{default: '0};
      rd_ptr_q <= '{default: '0};
      cnt_q    <= '{default: '0};
      dout_q   <= '{default: '0};
      vout_q   <= '0;
      err_q    <= '0;
    end else begin
      in_dat_q <= in_dat_d;
      in_vld_q <= in_vld_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      vout_q   <= vout_d;
      err_q    <= err_d;
    end
  end

  // Flatten per-channel output registers onto the packed data_out bus
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      data_out[i*DATA_W +: DATA_W] = dout_q[i];
    end
  end

  assign valid_out    = vout_q;
  assign fifo_empty   = is_empty;
  assign fifo_full    = is_full;
  assign almost_full  = is_af;
  assign almost_empty = is_ae;
  assign fifo_error   = err_q;
  assign pause        = |is_af;

endmodule

// File: tb/tb_class_switch_n.sv
// Directed bench for class_switch_n: vector table for routing/ordering, hand sequences for
// full/overflow, full with simultaneous read+write, underflow, disable and mid-operation reset.
module tb_class_switch_n;

  logic        clk;
  logic        reset;
  logic [9:0]  data_in;
  logic        valid_in;
  logic [3:0]  ch_en;
  logic [3:0]  read;
  logic [39:0] data_out;
  logic [3:0]  valid_out;
  logic [3:0]  fifo_empty;
  logic [3:0]  fifo_full;
  logic [3:0]  almost_full;
  logic [3:0]  almost_empty;
  logic [3:0]  fifo_error;
  logic        pause;

  int total = 0;
  int bad   = 0;

  class_switch_n #(
    .DATA_W(10), .CLASS_LSB(8), .NUM_CH(4), .FIFO_DEPTH(8), .AF_TH(6), .AE_TH(2)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .ch_en(ch_en),
    .read(read), .data_out(data_out), .valid_out(valid_out), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_error(fifo_error), .pause(pause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] din;
    logic       vld;
    logic [3:0] rd;
    logic [3:0] x_empty;
    logic [3:0] x_vout;
    int         ch;
    logic [9:0] x_dout;
    logic [3:0] x_err;
  } vec_t;

  vec_t tv [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] slice(input int ch);
    return data_out[ch*10 +: 10];
  endfunction

  task automatic send(input logic [9:0] w);
    data_in  = w;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_empty"}, 64'(fifo_empty),   64'hF);
    chk({tag, "_ae"},    64'(almost_empty), 64'hF);
    chk({tag, "_full"},  64'(fifo_full),    64'h0);
    chk({tag, "_af"},    64'(almost_full),  64'h0);
    chk({tag, "_err"},   64'(fifo_error),   64'h0);
    chk({tag, "_vout"},  64'(valid_out),    64'h0);
    chk({tag, "_pause"}, 64'(pause),        64'h0);
    chk({tag, "_dout"},  64'(data_out),     64'h0);
  endtask

  initial begin
    reset    = 1'b0;
    data_in  = '0;
    valid_in = 1'b0;
    ch_en    = 4'b1111;
    read     = 4'b0000;

    //          din     vld   rd       empty    vout     ch dout    err
    tv[0]  = '{10'h0FF, 1'b1, 4'b0000, 4'b1111, 4'b0000, 0, 10'h000, 4'b0000};
    tv[1]  = '{10'h1DD, 1'b1, 4'b0000, 4'b1110, 4'b0000, 0, 10'h000, 4'b0000};
    tv[2]  = '{10'h2EE, 1'b1, 4'b0000, 4'b1100, 4'b0000, 1, 10'h000, 4'b0000};
    tv[3]  = '{10'h3CC, 1'b1, 4'b0000, 4'b1000, 4'b0000, 2, 10'h000, 4'b0000};
    tv[4]  = '{10'h000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 3, 10'h000, 4'b0000};
    tv[5]  = '{10'h000, 1'b0, 4'b0001, 4'b0001, 4'b0001, 0, 10'h0FF, 4'b0000};
    tv[6]  = '{10'h000, 1'b0, 4'b0010, 4'b0011, 4'b0010, 1, 10'h1DD, 4'b0000};
    tv[7]  = '{10'h000, 1'b0, 4'b0100, 4'b0111, 4'b0100, 2, 10'h2EE, 4'b0000};
    tv[8]  = '{10'h000, 1'b0, 4'b1000, 4'b1111, 4'b1000, 3, 10'h3CC, 4'b0000};
    tv[9]  = '{10'h000, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3, 10'h3CC, 4'b0000};
    tv[10] = '{10'h0DD, 1'b1, 4'b0000, 4'b1111, 4'b0000, 0, 10'h0FF, 4'b0000};
    tv[11] = '{10'h0EE, 1'b1, 4'b0000, 4'b1110, 4'b0000, 0, 10'h0FF, 4'b0000};
    tv[12] = '{10'h0BB, 1'b1, 4'b0001, 4'b1110, 4'b0001, 0, 10'h0DD, 4'b0000};
    tv[13] = '{10'h000, 1'b0, 4'b0001, 4'b1110, 4'b0001, 0, 10'h0EE, 4'b0000};
    tv[14] = '{10'h000, 1'b0, 4'b0001, 4'b1111, 4'b0001, 0, 10'h0BB, 4'b0000};
    tv[15] = '{10'h000, 1'b0, 4'b0000, 4'b1111, 4'b0000, 0, 10'h0BB, 4'b0000};

    // Reset held for 4 cycles, then released
    repeat (4) tick();
    check_reset_state("in_reset");
    reset = 1'b1;
    tick();
    check_reset_state("after_release");

    // Routing and ordering/latency vectors
    for (int i = 0; i < 16; i++) begin
      data_in  = tv[i].din;
      valid_in = tv[i].vld;
      read     = tv[i].rd;
      tick();
      chk($sformatf("v%0d_empty", i), 64'(fifo_empty),        64'(tv[i].x_empty));
      chk($sformatf("v%0d_vout", i),  64'(valid_out),         64'(tv[i].x_vout));
      chk($sformatf("v%0d_dout", i),  64'(slice(tv[i].ch)),   64'(tv[i].x_dout));
      chk($sformatf("v%0d_err", i),   64'(fifo_error),        64'(tv[i].x_err));
    end
    valid_in = 1'b0;
    read     = 4'b0000;

    // Fill channel 1: almost_empty/almost_full/pause boundaries, full, overflow
    for (int j = 0; j < 6; j++) begin
      send(10'h100 + 10'(j));
      if (j == 2) chk("ae_at_cnt2", 64'(almost_empty), 64'hF);
      if (j == 3) chk("ae_at_cnt3", 64'(almost_empty), 64'hD);
    end
    chk("pause_at_cnt5", 64'(pause), 64'h0);
    tick();
    chk("af_at_cnt6",    64'(almost_full), 64'h2);
    chk("pause_at_cnt6", 64'(pause),       64'h1);
    chk("full_at_cnt6",  64'(fifo_full),   64'h0);
    send(10'h106);
    send(10'h107);
    tick();
    chk("full_at_cnt8", 64'(fifo_full),  64'h2);
    chk("err_at_cnt8",  64'(fifo_error), 64'h0);
    send(10'h1FF);
    tick();
    chk("ovf_err",       64'(fifo_error), 64'h2);
    chk("ovf_full_kept", 64'(fifo_full),  64'h2);
    for (int j = 0; j < 8; j++) begin
      read = 4'b0010;
      tick();
      chk($sformatf("ch1_rd%0d_vout", j), 64'(valid_out), 64'h2);
      chk($sformatf("ch1_rd%0d_dat", j),  64'(slice(1)),  64'(10'h100 + 10'(j)));
    end
    read = 4'b0000;
    tick();
    chk("ch1_drained_empty", 64'(fifo_empty), 64'hF);
    chk("ch1_drained_vout",  64'(valid_out),  64'h0);
    chk("ch1_pause_off",     64'(pause),      64'h0);
    chk("ch1_err_sticky",    64'(fifo_error), 64'h2);

    // Channel 2 full, simultaneous read and write
    for (int j = 0; j < 8; j++) send(10'h200 + 10'(j));
    data_in  = 10'h2AA;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("ch2_full_before", 64'(fifo_full), 64'h4);
    read = 4'b0100;
    tick();
    chk("ch2_rw_full",  64'(fifo_full),  64'h4);
    chk("ch2_rw_err",   64'(fifo_error), 64'h2);
    chk("ch2_rw_vout",  64'(valid_out),  64'h4);
    chk("ch2_rw_dat",   64'(slice(2)),   64'h200);
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk($sformatf("ch2_rd%0d_dat", j), 64'(slice(2)),
          (j < 8) ? 64'(10'h200 + 10'(j)) : 64'h2AA);
    end
    read = 4'b0000;
    tick();
    chk("ch2_drained_empty", 64'(fifo_empty), 64'hF);
    chk("ch2_drained_err",   64'(fifo_error), 64'h2);

    // Underflow on channel 3
    read = 4'b1000;
    tick();
    read = 4'b0000;
    chk("udf_vout", 64'(valid_out),  64'h0);
    chk("udf_err",  64'(fifo_error), 64'hA);

    // Disabled class 0 drops silently
    ch_en = 4'b1110;
    send(10'h077);
    tick();
    tick();
    chk("dis_empty", 64'(fifo_empty), 64'hF);
    chk("dis_err",   64'(fifo_error), 64'hA);
    ch_en = 4'b1111;

    // Mid-operation asynchronous reset with 3 words queued in channel 0
    send(10'h011);
    send(10'h022);
    send(10'h033);
    tick();
    chk("pre_rst_empty", 64'(fifo_empty), 64'hE);
    reset = 1'b0;
    #1;
    check_reset_state("mid_reset");
    tick();
    tick();
    reset = 1'b1;
    tick();
    read = 4'b0001;
    tick();
    read = 4'b0000;
    chk("post_rst_vout",  64'(valid_out),  64'h0);
    chk("post_rst_dout",  64'(data_out),   64'h0);
    chk("post_rst_empty", 64'(fifo_empty), 64'hF);
    chk("post_rst_err",   64'(fifo_error), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/class_switch_n.md
# class_switch_n

Parametrised N-channel class switch for the PCIe switching datapath. Each valid input word is steered by a class field in its header bits into one of NUM_CH per-class FIFOs. Every FIFO is drained independently by its own read strobe and reports empty, full, almost-full, almost-empty and sticky error status. An aggregate pause output backpressures the upstream source. A per-channel enable mask drops traffic for disabled classes silently.

## Interface
- DATA_W, 10, word width in bits.
- CLASS_LSB, 8, LSB of the class field inside the word.
- NUM_CH, 4, channel count; power of two, 2..8. The class field width CLASS_W = log2(NUM_CH) is a derived localparam.
- FIFO_DEPTH, 8, entries per channel FIFO; power of two, >= 4.
- AF_TH, 6, almost-full threshold in entries.
- AE_TH, 2, almost-empty threshold in entries; AE_TH < AF_TH <= FIFO_DEPTH.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  input word.
- valid_in  input  1  data_in is valid this cycle.
- ch_en  input  NUM_CH  channel enable mask; bit i enables class i.
- read  input  NUM_CH  per-channel pop strobe.
- data_out  output  NUM_CH*DATA_W  channel i output word in slice [i*DATA_W +: DATA_W].
- valid_out  output  NUM_CH  channel i data_out is valid this cycle.
- fifo_empty  output  NUM_CH  channel count == 0.
- fifo_full  output  NUM_CH  channel count == FIFO_DEPTH.
- almost_full  output  NUM_CH  channel count >= AF_TH.
- almost_empty  output  NUM_CH  channel count <= AE_TH.
- fifo_error  output  NUM_CH  sticky overflow/underflow flag.
- pause  output  1  OR of almost_full.

## Operation
- Input stage:
  - data_in and valid_in are registered once.
  - The registered word's class is c = word[CLASS_LSB +: CLASS_W].
- Write to FIFO c, when the registered word is valid:
  - ch_en[c] = 0: the word is dropped. No flag changes and no error.
  - FIFO c not full: the word is written and its count increments.
  - FIFO c full with read[c] accepted in the same cycle: the write is performed and the count is unchanged.
  - FIFO c full with no read: the word is dropped and fifo_error[c] is set.
- Read from channel i:
  - read[i] with count > 0: pops the head word. The word appears on data_out slice i the next cycle with valid_out[i] = 1 for exactly one cycle.
  - read[i] with count == 0: ignored and sets fifo_error[i]. There is no bypass, even if a write to channel i lands in the same cycle.
  - A simultaneous read and write on a non-empty, non-full channel leaves the count unchanged.
- data_out slice i holds its last popped value while valid_out[i] = 0.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.
- Status flags are combinational decodes of the registered count, so they reflect post-edge state.
- pause is advisory. The block keeps accepting words while pause = 1; overflow is handled per the write rules above.
- fifo_error clears only on reset.
- A ch_en change takes effect for the registered word in the same cycle. Already-queued words are unaffected.

## Timing
- Reset (asynchronous, any time, including mid-transfer) gives:
  - all pointers, counts, input register, data_out and valid_out = 0;
  - fifo_error = 0, fifo_full = 0, almost_full = 0, pause = 0;
  - fifo_empty = all ones, almost_empty = all ones.
- Queued words are discarded on reset.
- Release is synchronous to the next clk edge.
- Write latency: a word sampled at edge k is written at edge k+1. fifo_empty[c] falls after edge k+1.
- Minimum data latency: read[c] sampled at edge k+2 gives data_out/valid_out after edge k+2. That is 2 cycles from input sample to output valid.
- Throughput: one write per cycle aggregate, plus one read per channel per cycle.
- pause asserts in the cycle after the write that makes any count reach AF_TH. It deasserts in the cycle after the count drops below AF_TH.

## Test plan
- Reset and routing. Hold reset = 0 for 4 cycles, then release with default parameters. Check fifo_empty = 4'b1111, almost_empty = 4'b1111 and all other outputs 0. Then send 0x0FF, 0x1DD, 0x2EE, 0x3CC with ch_en = 4'b1111. Check counts 1,1,1,1; reading each channel returns the matching word with one-cycle valid_out.
- Ordering and latency. Send 0x0DD, 0x0EE, 0x0BB, then read channel 0 for 3 cycles. Check the output order is DD, EE, BB. Check the first valid_out occurs 2 cycles after the first word is sampled.
- Full, pause and overflow.
  - Write 6 words to class 1: almost_full[1] = 1 and pause = 1 the following cycle.
  - Write 2 more: fifo_full[1] = 1.
  - Write a 9th word with no read: it is dropped and fifo_error[1] = 1 (sticky).
  - Read 8 words: they equal the first 8 written.
- Full with simultaneous read and write. Fill channel 2 to 8 words, then assert read[2] while writing 0x2AA. Check no error, count stays 8, and 0x2AA is the last word read out.
- Underflow and disable.
  - read[3] on an empty channel: no valid_out and fifo_error[3] = 1.
  - With ch_en[0] = 0, send 0x077: channel 0 count stays 0 and fifo_error[0] = 0.
- Reset mid-operation. Assert reset with 3 words queued in channel 0. Check all outputs return to their reset values immediately, and channel 0 reads nothing afterwards.
